cp0_register_file: RTL and testbench

- Coprocessor-0 register file: the receiving end of the write-back stage's CP0 data bus.
- Accepts MTC0 writes and exception/ERET commits from WB, and holds Status, Cause, EPC, Count and Compare.
- Provides a combinational MFC0 read port to the pipeline.
- Produces the interrupt-pending flag and the flush redirect target used by fetch.

---
 rtl/cp0_register_file.sv | 167 ++++++++++++++++
 tb/tb_cp0_register_file.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_register_file.sv
// Coprocessor-0 register file: Status, Cause, EPC, Count and Compare, written by WB commits
// and read combinationally by MFC0; also drives the interrupt-pending flag and flush redirect.
module cp0_register_file #(
  parameter logic [31:0] EXCEPTION_ENTRY   = 32'hbfc00380,
  parameter int          COUNT_TICK_DIVIDE = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  address_register,
  input  logic [2:0]  address_select,
  input  logic        write_enabled,
  input  logic [31:0] write_data,
  input  logic        exception_valid,
  input  logic [31:0] exception_address,
  input  logic        eret_flush,
  input  logic        in_delay_slot,
  input  logic [4:0]  exception_code,
  input  logic [5:0]  hardware_interrupt,
  input  logic [4:0]  read_register,
  input  logic [2:0]  read_select,
  output logic [31:0] read_data,
  output logic        flush,
  output logic [31:0] flush_target,
  output logic        interrupt_pending,
  output logic        status_exl
);

  localparam int TICK_WIDTH = (COUNT_TICK_DIVIDE > 1) ? $clog2(COUNT_TICK_DIVIDE) : 1;
  localparam logic [TICK_WIDTH-1:0] TICK_LAST = TICK_WIDTH'(COUNT_TICK_DIVIDE - 1);

  logic [7:0]            status_im_r;
  logic                  status_exl_r;
  logic                  status_ie_r;
  logic                  cause_bd_r;
  logic                  cause_ti_r;
  logic [5:0]            cause_ip_hw_r;
  logic [1:0]            cause_ip_sw_r;
  logic [4:0]            cause_exc_code_r;
  logic [31:0]           epc_r;
  logic [31:0]           count_r;
  logic [31:0]           compare_r;
  logic [TICK_WIDTH-1:0] tick_r;

  logic        do_exception_s;
  logic        do_eret_s;
  logic        do_write_s;
  logic        wr_count_s;
  logic        wr_compare_s;
  logic        wr_status_s;
  logic        wr_cause_s;
  logic        wr_epc_s;
  logic        count_tick_s;
  logic        timer_match_s;
  logic [31:0] status_value_s;
  logic [31:0] cause_value_s;

  // Lower-priority commits are dropped entirely when a higher one arrives in the same cycle.
  assign do_exception_s = exception_valid;
  assign do_eret_s      = ~exception_valid & eret_flush;
  assign do_write_s     = ~exception_valid & ~eret_flush & write_enabled & (address_select == 3'd0);
  assign wr_count_s     = do_write_s & (address_register == 5'd9);
  assign wr_compare_s   = do_write_s & (address_register == 5'd11);
  assign wr_status_s    = do_write_s & (address_register == 5'd12);
  assign wr_cause_s     = do_write_s & (address_register == 5'd13);
  assign wr_epc_s       = do_write_s & (address_register == 5'd14);

  assign count_tick_s  = (tick_r == TICK_LAST);
  assign timer_match_s = (count_r == compare_r) & ((count_r != 32'd0) | (compare_r != 32'd0));

  assign status_value_s = {9'd0, 1'b1, 6'd0, status_im_r, 6'd0, status_exl_r, status_ie_r};
  assign cause_value_s  = {cause_bd_r, cause_ti_r, 14'd0, cause_ip_hw_r, cause_ip_sw_r,
                           1'b0, cause_exc_code_r, 2'd0};

  assign status_exl        = status_exl_r;
  assign flush             = exception_valid | eret_flush;
  assign interrupt_pending = (|(cause_value_s[15:8] & status_im_r)) & status_ie_r & ~status_exl_r;

  // Redirect target: exception entry wins, ERET returns to the EPC held before this commit.
  always_comb begin
    flush_target = 32'd0;
    if (exception_valid) begin
      flush_target = EXCEPTION_ENTRY;
    end else if (eret_flush) begin
      flush_target = epc_r;
    end else begin
      flush_target = 32'd0;
    end
  end

  // MFC0 read mux, no bypass of same-cycle writes.
  always_comb begin
    read_data = 32'd0;
    if (read_select == 3'd0) begin
      case (read_register)
        5'd9:    read_data = count_r;
        5'd11:   read_data = compare_r;
        5'd12:   read_data = status_value_s;
        5'd13:   read_data = cause_value_s;
        5'd14:   read_data = epc_r;
        default: read_data = 32'd0;
      endcase
    end else begin
      read_data = 32'd0;
    end
  end

  // Architectural state update.
  always_ff @(posedge clock) begin
    if (reset) begin
      status_im_r      <= 8'd0;
      status_exl_r     <= 1'b0;
      status_ie_r      <= 1'b0;
      cause_bd_r       <= 1'b0;
      cause_ti_r       <= 1'b0;
      cause_ip_hw_r    <= 6'd0;
      cause_ip_sw_r    <= 2'd0;
      cause_exc_code_r <= 5'd0;
      epc_r            <= 32'd0;
      count_r          <= 32'd0;
      compare_r        <= 32'd0;
      tick_r           <= '0;
    end else begin
      cause_ip_hw_r <= {hardware_interrupt[5] | cause_ti_r, hardware_interrupt[4:0]};

      if (wr_count_s) begin
        count_r <= write_data;
        tick_r  <= '0;
      end else if (count_tick_s) begin
        count_r <= count_r + 32'd1;
        tick_r  <= '0;
      end else begin
        tick_r  <= tick_r + 1'b1;
      end

      if (wr_compare_s) begin
        compare_r  <= write_data;
        cause_ti_r <= 1'b0;
      end else if (timer_match_s) begin
        cause_ti_r <= 1'b1;
      end

      if (do_exception_s) begin
        if (!status_exl_r) begin
          epc_r      <= in_delay_slot ? (exception_address - 32'd4) : exception_address;
          cause_bd_r <= in_delay_slot;
        end
        status_exl_r     <= 1'b1;
        cause_exc_code_r <= exception_code;
      end else if (do_eret_s) begin
        status_exl_r <= 1'b0;
      end else begin
        if (wr_status_s) begin
          status_im_r  <= write_data[15:8];
          status_exl_r <= write_data[1];
          status_ie_r  <= write_data[0];
        end
        if (wr_cause_s) begin
          cause_ip_sw_r <= write_data[9:8];
        end
        if (wr_epc_s) begin
          epc_r <= write_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_register_file.sv
// Scoreboard bench for cp0_register_file: directed stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cp0_register_file;

  logic        clock;
  logic        reset;
  logic [4:0]  address_register;
  logic [2:0]  address_select;
  logic        write_enabled;
  logic [31:0] write_data;
  logic        exception_valid;
  logic [31:0] exception_address;
  logic        eret_flush;
  logic        in_delay_slot;
  logic [4:0]  exception_code;
  logic [5:0]  hardware_interrupt;
  logic [4:0]  read_register;
  logic [2:0]  read_select;
  logic [31:0] read_data;
  logic        flush;
  logic [31:0] flush_target;
  logic        interrupt_pending;
  logic        status_exl;

  localparam int K_READ = 0;
  localparam int K_FLUSH = 1;
  localparam int K_TARGET = 2;
  localparam int K_PEND = 3;
  localparam int K_EXL = 4;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  cp0_register_file dut (
    .clock             (clock),
    .reset             (reset),
    .address_register  (address_register),
    .address_select    (address_select),
    .write_enabled     (write_enabled),
    .write_data        (write_data),
    .exception_valid   (exception_valid),
    .exception_address (exception_address),
    .eret_flush        (eret_flush),
    .in_delay_slot     (in_delay_slot),
    .exception_code    (exception_code),
    .hardware_interrupt(hardware_interrupt),
    .read_register     (read_register),
    .read_select       (read_select),
    .read_data         (read_data),
    .flush             (flush),
    .flush_target      (flush_target),
    .interrupt_pending (interrupt_pending),
    .status_exl        (status_exl)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: outputs are stable mid-cycle, so every queued expectation is checked at negedge.
  always @(negedge clock) begin
    exp_t it;
    logic [31:0] act;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      case (it.kind)
        K_READ:   act = read_data;
        K_FLUSH:  act = {31'd0, flush};
        K_TARGET: act = flush_target;
        K_PEND:   act = {31'd0, interrupt_pending};
        default:  act = {31'd0, status_exl};
      endcase
      checks++;
      if (act !== it.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input int kind, input logic [31:0] exp, input string name);
    exp_t it;
    it.kind = kind;
    it.exp  = exp;
    it.name = name;
    sb.push_back(it);
  endtask

  task automatic rd(input logic [4:0] r, input logic [2:0] s, input logic [31:0] exp,
                    input string name);
    read_register = r;
    read_select   = s;
    chk(K_READ, exp, name);
    tick();
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [2:0] s, input logic [31:0] d);
    address_register = r;
    address_select   = s;
    write_data       = d;
    write_enabled    = 1'b1;
    tick();
    write_enabled    = 1'b0;
  endtask

  task automatic exc(input logic [31:0] a, input logic ds, input logic [4:0] code);
    exception_valid   = 1'b1;
    exception_address = a;
    in_delay_slot     = ds;
    exception_code    = code;
  endtask

  initial begin
    reset = 1'b1;
    address_register = 5'd0;
    address_select = 3'd0;
    write_enabled = 1'b0;
    write_data = 32'd0;
    exception_valid = 1'b0;
    exception_address = 32'd0;
    eret_flush = 1'b0;
    in_delay_slot = 1'b0;
    exception_code = 5'd0;
    hardware_interrupt = 6'd0;
    read_register = 5'd0;
    read_select = 3'd0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // reset state
    chk(K_EXL, 32'd0, "reset_exl");
    chk(K_PEND, 32'd0, "reset_pending");
    chk(K_FLUSH, 32'd0, "reset_flush");
    chk(K_TARGET, 32'd0, "reset_target");
    rd(5'd9, 3'd0, 32'd0, "reset_count");
    rd(5'd12, 3'd0, 32'h0040_0000, "reset_status");
    rd(5'd13, 3'd0, 32'd0, "reset_cause");
    rd(5'd14, 3'd0, 32'd0, "reset_epc");

    // 1: Status write, select decoding, unimplemented registers
    mtc0(5'd12, 3'd0, 32'h0000_ff01);
    rd(5'd12, 3'd0, 32'h0040_ff01, "status_write");
    rd(5'd12, 3'd1, 32'd0, "status_sel1");
    mtc0(5'd3, 3'd0, 32'hffff_ffff);
    rd(5'd3, 3'd0, 32'd0, "unimpl_reg");

    // 2: exception in delay slot, then nested exception
    exc(32'hbfc0_1000, 1'b1, 5'h04);
    chk(K_FLUSH, 32'd1, "exc_flush");
    chk(K_TARGET, 32'hbfc0_0380, "exc_target");
    tick();
    exception_valid = 1'b0;
    chk(K_EXL, 32'd1, "exc_exl");
    rd(5'd14, 3'd0, 32'hbfc0_0ffc, "exc_epc");
    rd(5'd13, 3'd0, 32'h8000_0010, "exc_cause");
    exc(32'h0000_1234, 1'b0, 5'h08);
    tick();
    exception_valid = 1'b0;
    rd(5'd14, 3'd0, 32'hbfc0_0ffc, "nested_epc");
    rd(5'd13, 3'd0, 32'h8000_0020, "nested_cause");

    // 3: ERET, then ERET + exception + MTC0 EPC in one cycle
    eret_flush = 1'b1;
    chk(K_FLUSH, 32'd1, "eret_flush");
    chk(K_TARGET, 32'hbfc0_0ffc, "eret_target");
    tick();
    eret_flush = 1'b0;
    chk(K_EXL, 32'd0, "eret_exl");
    eret_flush = 1'b1;
    exc(32'h0000_2000, 1'b0, 5'h0c);
    address_register = 5'd14;
    address_select = 3'd0;
    write_data = 32'hdead_beef;
    write_enabled = 1'b1;
    chk(K_TARGET, 32'hbfc0_0380, "prio_target");
    tick();
    eret_flush = 1'b0;
    exception_valid = 1'b0;
    write_enabled = 1'b0;
    chk(K_EXL, 32'd1, "prio_exl");
    rd(5'd14, 3'd0, 32'h0000_2000, "prio_epc");
    rd(5'd13, 3'd0, 32'h0000_0030, "prio_cause");
    eret_flush = 1'b1;
    chk(K_TARGET, 32'h0000_2000, "eret2_target");
    tick();
    eret_flush = 1'b0;
    mtc0(5'd14, 3'd1, 32'h0000_1111);
    rd(5'd14, 3'd0, 32'h0000_2000, "epc_sel1_ignored");

    // 4: timer match and TI / IP7 / pending latency
    mtc0(5'd11, 3'd0, 32'd3);
    mtc0(5'd9, 3'd0, 32'd0);
    repeat (6) tick();
    rd(5'd9, 3'd0, 32'd3, "timer_count3");
    chk(K_PEND, 32'd0, "timer_pend_early");
    rd(5'd13, 3'd0, 32'h4000_0030, "timer_ti");
    chk(K_PEND, 32'd1, "timer_pending");
    rd(5'd13, 3'd0, 32'h4000_8030, "timer_ip7");
    mtc0(5'd11, 3'd0, 32'd12);
    mtc0(5'd9, 3'd0, 32'd10);
    repeat (4) tick();
    mtc0(5'd11, 3'd0, 32'd12);
    rd(5'd13, 3'd0, 32'h0000_0030, "ti_clear_wins");
    rd(5'd13, 3'd0, 32'h4000_0030, "ti_set_after");
    mtc0(5'd11, 3'd0, 32'hffff_0000);
    repeat (2) tick();

    // 5: Count wrap and hardware interrupt
    mtc0(5'd9, 3'd0, 32'hffff_ffff);
    rd(5'd9, 3'd0, 32'hffff_ffff, "count_max");
    tick();
    rd(5'd9, 3'd0, 32'd0, "count_wrap");
    hardware_interrupt = 6'b000001;
    chk(K_PEND, 32'd0, "hw_pend_latency");
    tick();
    chk(K_PEND, 32'd1, "hw_pending");
    rd(5'd13, 3'd0, 32'h0000_0430, "hw_cause_ip2");
    mtc0(5'd12, 3'd0, 32'h0000_ff03);
    chk(K_PEND, 32'd0, "hw_pend_exl");
    chk(K_EXL, 32'd1, "status_exl_write");
    hardware_interrupt = 6'd0;
    mtc0(5'd12, 3'd0, 32'h0000_ff01);
    tick();
    mtc0(5'd13, 3'd0, 32'hffff_ffff);
    chk(K_PEND, 32'd1, "sw_ip_pending");
    rd(5'd13, 3'd0, 32'h0000_0330, "cause_sw_ip");
    mtc0(5'd13, 3'd0, 32'd0);
    chk(K_PEND, 32'd0, "sw_ip_cleared");
    rd(5'd13, 3'd0, 32'h0000_0030, "cause_sw_clear");

    // 6: reset during counting with TI set
    mtc0(5'd11, 3'd0, 32'd2);
    mtc0(5'd9, 3'd0, 32'd0);
    repeat (5) tick();
    rd(5'd13, 3'd0, 32'h4000_0030, "pre_reset_ti");
    reset = 1'b1;
    hardware_interrupt = 6'b111111;
    address_register = 5'd14;
    write_data = 32'h0000_0055;
    write_enabled = 1'b1;
    tick();
    reset = 1'b0;
    hardware_interrupt = 6'd0;
    write_enabled = 1'b0;
    chk(K_EXL, 32'd0, "rst2_exl");
    chk(K_PEND, 32'd0, "rst2_pending");
    chk(K_FLUSH, 32'd0, "rst2_flush");
    rd(5'd9, 3'd0, 32'd0, "rst2_count");
    rd(5'd13, 3'd0, 32'd0, "rst2_cause");
    rd(5'd12, 3'd0, 32'h0040_0000, "rst2_status");
    rd(5'd14, 3'd0, 32'd0, "rst2_epc");
    rd(5'd11, 3'd0, 32'd0, "rst2_compare");

    tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
